// File: rtl/uarc_bus_responder_if.sv
// Bus bundle between the core (master) and uarc_bus_responder (slave).
// Carries the broadcast requests, per-bus ack pulses, drain readout and stats.
interface uarc_bus_responder_if #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned TOTAL_BUSES = 4,
  parameter int unsigned SEL_WIDTH   = 2
);
  logic                   global_kill;
  logic                   global_incept;
  logic                   global_send;
  logic                   global_stream;
  logic [WORD_WIDTH-1:0]  global_data;
  logic [TOTAL_BUSES-1:0] sender_enables;

  logic [TOTAL_BUSES-1:0] sender_kill_acks;
  logic [TOTAL_BUSES-1:0] sender_incept_acks;
  logic [TOTAL_BUSES-1:0] sender_send_acks;
  logic [TOTAL_BUSES-1:0] sender_stream_acks;

  logic [SEL_WIDTH-1:0]   drain_sel;
  logic                   drain_pop;
  logic                   drain_valid;
  logic [WORD_WIDTH-1:0]  drain_data;
  logic                   drain_is_stream;

  logic [15:0]            stat_count;

  modport master (
    output global_kill, global_incept, global_send, global_stream, global_data,
    output sender_enables, drain_sel, drain_pop,
    input  sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
    input  drain_valid, drain_data, drain_is_stream, stat_count
  );

  modport slave (
    input  global_kill, global_incept, global_send, global_stream, global_data,
    input  sender_enables, drain_sel, drain_pop,
    output sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
    output drain_valid, drain_data, drain_is_stream, stat_count
  );
endinterface

// File: rtl/uarc_bus_responder.sv
// Multi-bus request responder. Each bus runs an IDLE/WAIT/ACK FSM that acks the
// highest-priority broadcast request after ACK_LATENCY cycles; send/stream payloads
// are queued in a per-bus FIFO read out through the drain port, kill flushes it.
// Optional macro UARC_BUS_RESPONDER_STATS_EN builds a saturating ack counter;
// without it stat_count is tied to zero.
// FIFO_MAG must be at least 1.
module uarc_bus_responder #(
  parameter int unsigned WORD_MAG    = 5,
  parameter int unsigned TOTAL_BUSES = 4,
  parameter int unsigned FIFO_MAG    = 2,
  parameter int unsigned ACK_LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  uarc_bus_responder_if.slave bus
);

  localparam int unsigned WORD_WIDTH = 1 << WORD_MAG;
  localparam int unsigned SEL_WIDTH  = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;
  localparam int unsigned DEPTH      = 1 << FIFO_MAG;
  localparam int unsigned PW         = FIFO_MAG + 1;
  // Pointers differ only in the wrap bit when the FIFO is full.
  localparam logic [PW-1:0] FullXor  = PW'(DEPTH);
  localparam logic [3:0]    CntLoad  = 4'(ACK_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
  typedef enum logic [1:0] {TyKill, TyIncept, TySend, TyStream} req_type_e;

  // Per-bus FSM state
  state_e    state_q [TOTAL_BUSES];
  state_e    state_d [TOTAL_BUSES];
  req_type_e type_q  [TOTAL_BUSES];
  req_type_e type_d  [TOTAL_BUSES];
  logic [3:0] cnt_q  [TOTAL_BUSES];
  logic [3:0] cnt_d  [TOTAL_BUSES];

  logic [TOTAL_BUSES-1:0] kill_ack_q, kill_ack_d;
  logic [TOTAL_BUSES-1:0] incept_ack_q, incept_ack_d;
  logic [TOTAL_BUSES-1:0] send_ack_q, send_ack_d;
  logic [TOTAL_BUSES-1:0] stream_ack_q, stream_ack_d;

  // Per-bus FIFO: entry is {is_stream, data}
  logic [WORD_WIDTH:0] mem_q  [TOTAL_BUSES][DEPTH];
  logic [PW-1:0]       wptr_q [TOTAL_BUSES];
  logic [PW-1:0]       rptr_q [TOTAL_BUSES];

  logic [TOTAL_BUSES-1:0] full;
  logic [TOTAL_BUSES-1:0] empty;
  logic [TOTAL_BUSES-1:0] push;
  logic [TOTAL_BUSES-1:0] pop;
  logic [TOTAL_BUSES-1:0] flush;
  logic [TOTAL_BUSES-1:0] live;

  logic                   any_req;
  logic [SEL_WIDTH-1:0]   sel;
  logic [SEL_WIDTH-1:0]   sel_idx;
  logic                   sel_ok;
  logic [TOTAL_BUSES-1:0] sel_dec;
  logic [WORD_WIDTH:0]    head;

  assign any_req = bus.global_kill | bus.global_incept | bus.global_send | bus.global_stream;

  // FIFO status flags from the current (pre-edge) pointers
  always_comb begin
    full  = '0;
    empty = '0;
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      full[b]  = ((wptr_q[b] ^ rptr_q[b]) == FullXor);
      empty[b] = (wptr_q[b] == rptr_q[b]);
    end
  end

  // Whether each bus's latched request is still being asserted
  always_comb begin
    live = '0;
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      unique case (type_q[b])
        TyKill:   live[b] = bus.global_kill   & bus.sender_enables[b];
        TyIncept: live[b] = bus.global_incept & bus.sender_enables[b];
        TySend:   live[b] = bus.global_send   & bus.sender_enables[b];
        TyStream: live[b] = bus.global_stream & bus.sender_enables[b];
        default:  live[b] = 1'b0;
      endcase
    end
  end

  // Next-state, ack and FIFO-control logic for every bus FSM
  always_comb begin
    kill_ack_d   = '0;
    incept_ack_d = '0;
    send_ack_d   = '0;
    stream_ack_d = '0;
    push         = '0;
    flush        = '0;
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      state_d[b] = state_q[b];
      type_d[b]  = type_q[b];
      cnt_d[b]   = cnt_q[b];
      unique case (state_q[b])
        StIdle: begin
          if (any_req && bus.sender_enables[b]) begin
            if (bus.global_kill)        type_d[b] = TyKill;
            else if (bus.global_incept) type_d[b] = TyIncept;
            else if (bus.global_send)   type_d[b] = TySend;
            else                        type_d[b] = TyStream;
            cnt_d[b]   = CntLoad;
            state_d[b] = StWait;
          end
        end
        StWait: begin
          if (!live[b]) begin
            state_d[b] = StIdle;
          end else if (cnt_q[b] != 4'd0) begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end else if ((type_q[b] == TySend || type_q[b] == TyStream) && full[b]) begin
            // Hold until a pop has freed a slot before this edge.
            state_d[b] = StWait;
          end else begin
            state_d[b] = StAck;
            unique case (type_q[b])
              TyKill: begin
                kill_ack_d[b] = 1'b1;
                flush[b]      = 1'b1;
              end
              TyIncept: incept_ack_d[b] = 1'b1;
              TySend: begin
                send_ack_d[b] = 1'b1;
                push[b]       = 1'b1;
              end
              TyStream: begin
                stream_ack_d[b] = 1'b1;
                push[b]         = 1'b1;
              end
              default: state_d[b] = StIdle;
            endcase
          end
        end
        StAck:   state_d[b] = StIdle;
        default: state_d[b] = StIdle;
      endcase
    end
  end

  // FSM and ack registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < TOTAL_BUSES; b++) begin
        state_q[b] <= StIdle;
        type_q[b]  <= TyKill;
        cnt_q[b]   <= 4'd0;
      end
      kill_ack_q   <= '0;
      incept_ack_q <= '0;
      send_ack_q   <= '0;
      stream_ack_q <= '0;
    end else begin
      for (int b = 0; b < TOTAL_BUSES; b++) begin
        state_q[b] <= state_d[b];
        type_q[b]  <= type_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      kill_ack_q   <= kill_ack_d;
      incept_ack_q <= incept_ack_d;
      send_ack_q   <= send_ack_d;
      stream_ack_q <= stream_ack_d;
    end
  end

  assign bus.sender_kill_acks   = kill_ack_q;
  assign bus.sender_incept_acks = incept_ack_q;
  assign bus.sender_send_acks   = send_ack_q;
  assign bus.sender_stream_acks = stream_ack_q;

  // Drain select decode; out-of-range selects read as empty
  always_comb begin
    sel     = bus.drain_sel;
    sel_ok  = (32'(sel) < TOTAL_BUSES);
    sel_idx = sel_ok ? sel : '0;
    sel_dec = '0;
    if (sel_ok) sel_dec = TOTAL_BUSES'(1) << sel;
    head    = mem_q[sel_idx][rptr_q[sel_idx][FIFO_MAG-1:0]];
  end

  assign bus.drain_valid     = sel_ok & ~empty[sel_idx];
  assign bus.drain_data      = head[WORD_WIDTH-1:0];
  assign bus.drain_is_stream = head[WORD_WIDTH];

  // A kill flush on the same edge takes precedence over a pop
  always_comb begin
    pop = '0;
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      pop[b] = bus.drain_pop & sel_dec[b] & ~empty[b] & ~flush[b];
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < TOTAL_BUSES; b++) begin
        wptr_q[b] <= '0;
        rptr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < TOTAL_BUSES; b++) begin
        if (flush[b]) begin
          wptr_q[b] <= '0;
          rptr_q[b] <= '0;
        end else begin
          if (push[b]) wptr_q[b] <= wptr_q[b] + PW'(1);
          if (pop[b])  rptr_q[b] <= rptr_q[b] + PW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      if (push[b]) begin
        mem_q[b][wptr_q[b][FIFO_MAG-1:0]] <= {(type_q[b] == TyStream), bus.global_data};
      end
    end
  end

`ifdef UARC_BUS_RESPONDER_STATS_EN
  logic [15:0]            stat_q;
  logic [TOTAL_BUSES-1:0] ack_any;
  logic [6:0]             ack_sum;
  logic [16:0]            stat_sum;

  // Sum acks entering this edge so the count moves with the ack pulses
  always_comb begin
    ack_any = kill_ack_d | incept_ack_d | send_ack_d | stream_ack_d;
    ack_sum = '0;
    for (int b = 0; b < TOTAL_BUSES; b++) begin
      ack_sum = ack_sum + 7'(ack_any[b]);
    end
    stat_sum = {1'b0, stat_q} + 17'(ack_sum);
  end

  // Saturating transaction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end
  end

  assign bus.stat_count = stat_q;
`else
  assign bus.stat_count = '0;
`endif

endmodule

// File: tb/tb_uarc_bus_responder.sv
// Directed bench for uarc_bus_responder: latency, priority, FIFO full/hold, kill
// flush, drop during WAIT, reset mid-WAIT and the optional stats counter.
module tb_uarc_bus_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_stat = 0;

`ifdef UARC_BUS_RESPONDER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  always #5 clk = ~clk;

  uarc_bus_responder_if #(.WORD_WIDTH(32), .TOTAL_BUSES(4), .SEL_WIDTH(2)) bus_if ();
  uarc_bus_responder_if #(.WORD_WIDTH(32), .TOTAL_BUSES(4), .SEL_WIDTH(2)) bus4_if ();

  uarc_bus_responder #(
    .WORD_MAG(5), .TOTAL_BUSES(4), .FIFO_MAG(2), .ACK_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  uarc_bus_responder #(
    .WORD_MAG(5), .TOTAL_BUSES(4), .FIFO_MAG(2), .ACK_LATENCY(4)
  ) dut4 (
    .clk(clk), .reset(reset), .bus(bus4_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // req bits: [3] kill [2] incept [1] send [0] stream
  task automatic set_req(input logic [3:0] req);
    bus_if.global_kill   = req[3];
    bus_if.global_incept = req[2];
    bus_if.global_send   = req[1];
    bus_if.global_stream = req[0];
  endtask

  task automatic check_stat(input string tag);
    check(tag, 32'(bus_if.stat_count), StatsEn ? 32'(exp_stat) : 32'd0);
  endtask

  // One ACK_LATENCY=2 transaction; exp_ty is the one-hot ack type expected.
  task automatic txn(input string tag, input logic [3:0] req, input logic [3:0] exp_ty,
                     input logic [3:0] en, input logic [31:0] data);
    logic [3:0] e;
    bus_if.sender_enables = en;
    bus_if.global_data    = data;
    set_req(req);
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = (k == 3) ? en : 4'b0000;
      check({tag, "/kill"},   32'(bus_if.sender_kill_acks),   32'(exp_ty[3] ? e : 4'b0));
      check({tag, "/incept"}, 32'(bus_if.sender_incept_acks), 32'(exp_ty[2] ? e : 4'b0));
      check({tag, "/send"},   32'(bus_if.sender_send_acks),   32'(exp_ty[1] ? e : 4'b0));
      check({tag, "/stream"}, 32'(bus_if.sender_stream_acks), 32'(exp_ty[0] ? e : 4'b0));
    end
    exp_stat += $countones(en);
    check_stat({tag, "/stat"});
    set_req(4'b0000);
    bus_if.sender_enables = '0;
    tick();
  endtask

  task automatic pop_one();
    bus_if.drain_pop = 1'b1;
    tick();
    bus_if.drain_pop = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fifo_exp [4];
    logic        ack_exp;
    set_req(4'b0000);
    bus_if.global_data    = '0;
    bus_if.sender_enables = '0;
    bus_if.drain_sel      = '0;
    bus_if.drain_pop      = 1'b0;
    bus4_if.global_kill    = 1'b0;
    bus4_if.global_incept  = 1'b0;
    bus4_if.global_send    = 1'b0;
    bus4_if.global_stream  = 1'b0;
    bus4_if.global_data    = '0;
    bus4_if.sender_enables = '0;
    bus4_if.drain_sel      = '0;
    bus4_if.drain_pop      = 1'b0;

    tick();
    tick();
    check("rst/kill",  32'(bus_if.sender_kill_acks), 32'd0);
    check("rst/send",  32'(bus_if.sender_send_acks), 32'd0);
    check("rst/valid", 32'(bus_if.drain_valid), 32'd0);
    check("rst/stat",  32'(bus_if.stat_count), 32'd0);
    reset = 1'b0;

    // Send then stream on bus 1
    bus_if.drain_sel = 2'd1;
    txn("send_b1", 4'b0010, 4'b0010, 4'b0010, 32'hDEADBEEF);
    check("b1/valid", 32'(bus_if.drain_valid), 32'd1);
    check("b1/data", bus_if.drain_data, 32'hDEADBEEF);
    check("b1/is_stream", 32'(bus_if.drain_is_stream), 32'd0);
    pop_one();
    check("b1/valid_after_pop", 32'(bus_if.drain_valid), 32'd0);
    txn("stream_b1", 4'b0001, 4'b0001, 4'b0010, 32'h12345678);
    check("b1s/data", bus_if.drain_data, 32'h12345678);
    check("b1s/is_stream", 32'(bus_if.drain_is_stream), 32'd1);
    pop_one();
    check("b1s/valid_after_pop", 32'(bus_if.drain_valid), 32'd0);

    // Pop of an empty FIFO must not move its pointers
    bus_if.drain_sel = 2'd0;
    pop_one();
    check("empty_pop/valid", 32'(bus_if.drain_valid), 32'd0);

    // Request dropped during WAIT: no ack, no push
    bus_if.sender_enables = 4'b0001;
    set_req(4'b0010);
    tick();
    set_req(4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop/send", 32'(bus_if.sender_send_acks), 32'd0);
    end
    check("drop/valid", 32'(bus_if.drain_valid), 32'd0);

    // Five back-to-back sends on bus 0; fifth waits for a pop
    set_req(4'b0010);
    for (int k = 1; k <= 27; k++) begin
      bus_if.global_data = 32'h100 + k;
      bus_if.drain_pop   = (k == 26);
      tick();
      ack_exp = (k == 3 || k == 7 || k == 11 || k == 15 || k == 27);
      check($sformatf("full/ack%0d", k), 32'(bus_if.sender_send_acks), 32'(ack_exp));
    end
    check("full/head_after_pop", bus_if.drain_data, 32'h107);
    set_req(4'b0000);
    bus_if.sender_enables = '0;
    bus_if.drain_pop      = 1'b0;
    exp_stat += 5;
    check_stat("full/stat");
    tick();
    fifo_exp = '{32'h107, 32'h10B, 32'h10F, 32'h11B};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full/valid%0d", i), 32'(bus_if.drain_valid), 32'd1);
      check($sformatf("full/data%0d", i), bus_if.drain_data, fifo_exp[i]);
      pop_one();
    end
    check("full/drained", 32'(bus_if.drain_valid), 32'd0);

    // Kill beats send on bus 2 and flushes three queued entries
    bus_if.drain_sel = 2'd2;
    txn("q2a", 4'b0010, 4'b0010, 4'b0100, 32'hA1);
    txn("q2b", 4'b0010, 4'b0010, 4'b0100, 32'hA2);
    txn("q2c", 4'b0010, 4'b0010, 4'b0100, 32'hA3);
    check("q2/head", bus_if.drain_data, 32'hA1);
    txn("kill_send", 4'b1010, 4'b1000, 4'b0100, 32'hBB);
    check("kill/valid", 32'(bus_if.drain_valid), 32'd0);

    // Incept on two buses: ack only, no FIFO effect
    txn("incept_b13", 4'b0100, 4'b0100, 4'b1010, 32'hCC);
    bus_if.drain_sel = 2'd1;
    check("incept/valid_b1", 32'(bus_if.drain_valid), 32'd0);

    // Incept outranks stream
    bus_if.drain_sel = 2'd3;
    txn("incept_stream", 4'b0101, 4'b0100, 4'b1000, 32'hDD);
    check("incept_stream/valid_b3", 32'(bus_if.drain_valid), 32'd0);

    // Reset one cycle after a request on the ACK_LATENCY=4 instance
    bus4_if.sender_enables = 4'b1000;
    bus4_if.global_send    = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    bus4_if.global_send    = 1'b0;
    bus4_if.sender_enables = '0;
    tick();
    reset = 1'b0;
    exp_stat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rst4/send", 32'(bus4_if.sender_send_acks), 32'd0);
    end
    check("rst4/kill",   32'(bus4_if.sender_kill_acks), 32'd0);
    check("rst4/incept", 32'(bus4_if.sender_incept_acks), 32'd0);
    check("rst4/stream", 32'(bus4_if.sender_stream_acks), 32'd0);
    check("rst4/valid",  32'(bus4_if.drain_valid), 32'd0);
    check("rst4/stat",   32'(bus4_if.stat_count), 32'd0);
    check_stat("rst/stat_after");

`ifdef UARC_BUS_RESPONDER_STATS_EN
    // 4 acks every 4 cycles; run past 65535 acks to reach saturation
    bus_if.sender_enables = 4'b1111;
    set_req(4'b0100);
    for (int k = 0; k < 16400 * 4; k++) tick();
    set_req(4'b0000);
    bus_if.sender_enables = '0;
    check("stat/saturate", 32'(bus_if.stat_count), 32'h0000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uarc_bus_responder.md
UARC_BUS_RESPONDER -- requirements
Module: uarc_bus_responder

Interface
REQ-001 SHALL have parameter WORD_MAG, default 5, giving word width WORD_WIDTH = 1 << WORD_MAG.
REQ-002 SHALL have parameter TOTAL_BUSES, default 4, giving the number of buses served (1..64); SEL_WIDTH = max(1, clog2(TOTAL_BUSES)).
REQ-003 SHALL have parameter FIFO_MAG, default 2, giving per-bus FIFO depth 1 << FIFO_MAG.
REQ-004 SHALL have parameter ACK_LATENCY, default 2, giving cycles from request sample to ack (1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have ports global_kill, global_incept, global_send, global_stream, inputs, 1 bit each: the core's broadcast requests.
REQ-008 SHALL have port global_data, input, WORD_WIDTH: the broadcast payload.
REQ-009 SHALL have port sender_enables, input, TOTAL_BUSES: per-bus request qualifier.
REQ-010 SHALL have ports sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks, outputs, TOTAL_BUSES each: registered per-bus ack pulses.
REQ-011 SHALL have ports drain_sel (input, SEL_WIDTH) and drain_pop (input, 1): bus select and pop strobe for readout.
REQ-012 SHALL have ports drain_valid (output, 1), drain_data (output, WORD_WIDTH) and drain_is_stream (output, 1): head of the selected FIFO, combinational from drain_sel.
REQ-013 SHALL have port stat_count, output, 16: the total of acked transactions across all buses.

Function
REQ-014 Each bus SHALL run an independent FSM with states IDLE, WAIT and ACK.
REQ-015 In IDLE, a request on bus b (any global_* high with sender_enables[b] high) SHALL latch its type and load the latency counter with ACK_LATENCY-1, then enter WAIT.
REQ-016 When several requests are present, type priority SHALL be kill > incept > send > stream; only one type is latched.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at zero, the FSM SHALL enter ACK, except send/stream with a full FIFO, which SHALL hold in WAIT.
REQ-018 In ACK (exactly one cycle), the matching ack bit SHALL be high; the FSM SHALL then return to IDLE, and a request still high next cycle SHALL count as a new transaction.
REQ-019 If the request drops during WAIT, the FSM SHALL return to IDLE without an ack.
REQ-020 Timing: a request first sampled at edge T SHALL give an ack visible after edge T+ACK_LATENCY.
REQ-021 For send/stream, global_data SHALL be pushed on the edge entering ACK, tagged is_stream.
REQ-022 Fullness SHALL use the pre-edge count; a same-cycle pop on a full FIFO SHALL NOT admit a push, delaying the ack by one cycle.
REQ-023 Kill SHALL flush bus b's FIFO on the edge entering ACK; a pop in that same cycle SHALL be ignored.
REQ-024 drain_pop SHALL pop the FIFO selected by drain_sel; a pop of an empty FIFO or an out-of-range drain_sel SHALL be ignored, with drain_valid 0.
REQ-025 FIFO pointers SHALL be FIFO_MAG+1 bits and wrap modulo 2·depth; full = pointer MSBs differ and LSBs are equal.
REQ-026 Incept SHALL be ack-only, with no FIFO effect.

Reset
REQ-027 While reset is high, all FSMs SHALL go to IDLE, all FIFOs SHALL empty, and all acks, drain_valid and stat_count SHALL be 0.
REQ-028 Reset mid-WAIT SHALL discard the pending transaction with no ack.
REQ-029 drain_data SHALL be don't-care while drain_valid is 0.

Configuration
REQ-030 With macro UARC_BUS_RESPONDER_STATS_EN defined, stat_count SHALL increment once per ack pulse (summed over all buses in a cycle) and saturate at 0xFFFF.
REQ-031 Without UARC_BUS_RESPONDER_STATS_EN, stat_count SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-032 ACK_LATENCY=2, bus 1 enabled, global_send high with data 0xDEADBEEF at T -> sender_send_acks=4'b0010 after T+2 for one cycle; drain_sel=1 gives drain_valid=1, data 0xDEADBEEF, is_stream=0.
REQ-033 FIFO_MAG=2: five sends on bus 0 with no pops -> four acks, fifth held in WAIT; one pop -> fifth ack one cycle after the pop edge.
REQ-034 global_kill and global_send high together on bus 2 with 3 entries queued -> kill ack only, FIFO empty, drain_valid=0.
REQ-035 Reset asserted one cycle after a request on bus 3 (ACK_LATENCY=4) -> no ack ever; all outputs 0.
REQ-036 STATS_EN defined: 70000 single-bus acks -> stat_count=0xFFFF; same run without the macro -> stat_count=0 throughout.
